// File: rtl/servo_frame_tx_pkg.sv
// rtl/servo_frame_tx_pkg.sv - shared FSM encoding, frame layout constants and frame builder
package servo_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_LAST = 2'd3
  } state_t;

  localparam int FRAME_LEN = 5;
  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  localparam logic [2:0] IDX_HDR  = 3'd0;
  localparam logic [2:0] IDX_CH   = 3'd1;
  localparam logic [2:0] IDX_POSH = 3'd2;
  localparam logic [2:0] IDX_POSL = 3'd3;
  localparam logic [2:0] IDX_CHK  = 3'd4;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  // Checksum covers the channel and both position bytes, not the header.
  function automatic frame_t build_frame(input logic [7:0] header,
                                         input logic [4:0] ch,
                                         input logic [11:0] pos);
    frame_t f;
    f[IDX_HDR]  = header;
    f[IDX_CH]   = {3'b000, ch};
    f[IDX_POSH] = {4'b0000, pos[11:8]};
    f[IDX_POSL] = pos[7:0];
    f[IDX_CHK]  = f[IDX_CH] ^ f[IDX_POSH] ^ f[IDX_POSL];
    return f;
  endfunction

endpackage

// File: rtl/servo_frame_tx_if.sv
// rtl/servo_frame_tx_if.sv - command and SPI-byte handshake bundle for servo_frame_tx
interface servo_frame_tx_if;
  logic        I_cmd_valid;
  logic [4:0]  I_cmd_ch;
  logic [11:0] I_cmd_pos;
  logic        O_cmd_ready;
  logic        O_tx_en;
  logic [7:0]  O_data_out;
  logic        I_tx_done;
  logic        O_busy;
  logic        O_frame_done;
  logic        O_cmd_err;

  modport master (
    output I_cmd_valid, I_cmd_ch, I_cmd_pos, I_tx_done,
    input  O_cmd_ready, O_tx_en, O_data_out, O_busy, O_frame_done, O_cmd_err
  );

  modport slave (
    input  I_cmd_valid, I_cmd_ch, I_cmd_pos, I_tx_done,
    output O_cmd_ready, O_tx_en, O_data_out, O_busy, O_frame_done, O_cmd_err
  );
endinterface

// File: rtl/servo_cmd_fifo.sv
// rtl/servo_cmd_fifo.sv - synchronous command FIFO with occupancy counter and full/empty flags
module servo_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/servo_frame_tx.sv
// rtl/servo_frame_tx.sv - queues servo commands and serialises each as a 5-byte frame to an SPI master
module servo_frame_tx
  import servo_frame_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = DEFAULT_HEADER,
  parameter int         MAX_CH     = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  servo_frame_tx_if.slave bus
);
  localparam logic [4:0] MAX_CH_L = 5'(MAX_CH);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  frame_t      frame;
  frame_t      frame_built;
  logic [16:0] pop_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        accept;
  logic        ch_bad;
  logic        push;
  logic        busy_q;
  logic        err_q;

  assign pop    = (state == ST_LOAD);
  assign accept = bus.I_cmd_valid && bus.O_cmd_ready;
  assign ch_bad = (bus.I_cmd_ch > MAX_CH_L);
  assign push   = accept && !ch_bad;

  servo_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(17)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({bus.I_cmd_ch, bus.I_cmd_pos}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign frame_built = build_frame(HEADER, pop_data[16:12], pop_data[11:0]);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD: begin
        state_nxt = ST_SEND;
        idx_nxt   = IDX_HDR;
      end
      ST_SEND: begin
        if (bus.I_tx_done) begin
          if (idx == IDX_CHK) state_nxt = ST_LAST;
          else                idx_nxt   = idx + 3'd1;
        end
      end
      ST_LAST: begin
        state_nxt = fifo_empty ? ST_IDLE : ST_LOAD;
        idx_nxt   = IDX_HDR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= IDX_HDR;
      frame  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      if (state == ST_LOAD) frame <= frame_built;
      busy_q <= (state != ST_IDLE) || !fifo_empty;
      err_q  <= accept && ch_bad;
    end
  end

  // A LOAD pop frees a slot in the same cycle, so ready stays high even when full.
  assign bus.O_cmd_ready  = !fifo_full || pop;
  assign bus.O_tx_en      = (state == ST_SEND);
  assign bus.O_data_out   = (state == ST_SEND) ? frame[idx] : 8'h00;
  assign bus.O_frame_done = (state == ST_LAST);
  assign bus.O_busy       = busy_q;
  assign bus.O_cmd_err    = err_q;
endmodule

// File: tb/tb_servo_frame_tx.sv
// tb/tb_servo_frame_tx.sv - directed bench for servo_frame_tx with a stallable SPI byte model
module tb_servo_frame_tx;
  logic clk;
  logic rst_n;
  servo_frame_tx_if bus ();

  servo_frame_tx #(.FIFO_DEPTH(4), .HEADER(8'hAA), .MAX_CH(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI master model and output monitor share one process to keep sampling order fixed.
  logic       spi_stall = 1'b0;
  logic       spi_done = 1'b0;
  logic       force_done = 1'b0;
  logic       prev_tx_en = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         spi_cnt = 0;
  int         bif = 0;
  int         frames = 0;
  int         err_cnt = 0;
  int         gap_errs = 0;
  int         stab_errs = 0;
  logic [7:0] rx_q [$];

  assign bus.I_tx_done = spi_done | force_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      spi_cnt = 0;
      bif = 0;
      spi_done = 1'b0;
      prev_tx_en = 1'b0;
    end else begin
      if (bus.O_tx_en && prev_tx_en && !spi_done && bus.O_data_out != prev_data) stab_errs++;
      if (bus.O_frame_done) begin
        frames++;
        chk("frame_len", bif, 5);
        bif = 0;
      end
      if (bus.O_cmd_err) err_cnt++;
      if (!bus.O_tx_en && bif > 0 && bif < 5) gap_errs++;
      if (bus.O_tx_en && !spi_stall && !spi_done) begin
        spi_cnt++;
        if (spi_cnt == 16) begin
          spi_done = 1'b1;
          spi_cnt = 0;
          rx_q.push_back(bus.O_data_out);
          bif++;
        end
      end else begin
        if (!bus.O_tx_en || spi_stall) spi_cnt = 0;
        spi_done = 1'b0;
      end
      prev_tx_en = bus.O_tx_en;
      prev_data = bus.O_data_out;
    end
  end

  task automatic send_cmd(input logic [4:0] ch, input logic [11:0] pos);
    @(negedge clk);
    bus.I_cmd_valid = 1'b1;
    bus.I_cmd_ch = ch;
    bus.I_cmd_pos = pos;
    @(negedge clk);
    bus.I_cmd_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && frames < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, frames, target);
  endtask

  task automatic wait_tx_en(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.O_tx_en; i++) @(negedge clk);
    chk(tag, bus.O_tx_en, 1);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp [], input int n);
    chk(tag, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) chk(tag, rx_q[i], exp[i]);
  endtask

  logic [7:0] exp1 [] = '{8'hAA, 8'h03, 8'h05, 8'hA7, 8'hA1};
  logic [7:0] exp4 [] = '{8'hAA, 8'h01, 8'h01, 8'h23, 8'h23,
                          8'hAA, 8'h02, 8'h02, 8'h34, 8'h34,
                          8'hAA, 8'h05, 8'h00, 8'hFF, 8'hFA,
                          8'hAA, 8'h11, 8'h0A, 8'hBC, 8'hA7,
                          8'hAA, 8'h00, 8'h00, 8'h01, 8'h01,
                          8'hAA, 8'h10, 8'h0F, 8'hED, 8'hF2};
  logic [4:0]  t4_ch  [5] = '{5'd2, 5'd5, 5'd17, 5'd0, 5'd9};
  logic [11:0] t4_pos [5] = '{12'h234, 12'h0FF, 12'hABC, 12'h001, 12'h999};
  logic        t4_acc [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int f0;
    logic acc6;
    rst_n = 1'b0;
    bus.I_cmd_valid = 1'b0;
    bus.I_cmd_ch = '0;
    bus.I_cmd_pos = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", bus.O_tx_en, 0);
    chk("rst_data_out", bus.O_data_out, 8'h00);
    chk("rst_frame_done", bus.O_frame_done, 0);
    chk("rst_cmd_err", bus.O_cmd_err, 0);
    chk("rst_busy", bus.O_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", bus.O_cmd_ready, 1);

    // single frame, SPI answering 16 cycles after each byte
    rx_q.delete();
    send_cmd(5'd3, 12'h5A7);
    wait_frames("t1_frames", 1, 300);
    check_bytes("t1_byte", exp1, 5);
    repeat (3) @(negedge clk);
    chk("t1_busy_idle", bus.O_busy, 0);

    // illegal channel: one error pulse, nothing queued or sent
    send_cmd(5'd18, 12'h100);
    chk("t2_err_pulse", bus.O_cmd_err, 1);
    @(negedge clk);
    chk("t2_err_clear", bus.O_cmd_err, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t2_quiet", {bus.O_tx_en, bus.O_busy}, 2'b00);
    end

    // spurious tx_done while idle
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    chk("t3_idle_outputs", {bus.O_tx_en, bus.O_data_out, bus.O_busy, bus.O_frame_done, bus.O_cmd_ready},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

    // engine stalled in SEND, then five back-to-back offers into the 4-deep FIFO
    rx_q.delete();
    f0 = frames;
    spi_stall = 1'b1;
    send_cmd(5'd1, 12'h123);
    wait_tx_en("t4_first_send", 20);
    for (int i = 0; i < 5; i++) begin
      bus.I_cmd_valid = 1'b1;
      bus.I_cmd_ch = t4_ch[i];
      bus.I_cmd_pos = t4_pos[i];
      chk("t4_ready", bus.O_cmd_ready, t4_acc[i]);
      @(negedge clk);
    end
    bus.I_cmd_valid = 1'b0;
    chk("t4_full_ready", bus.O_cmd_ready, 0);
    chk("t4_busy", bus.O_busy, 1);
    // hold a command while full; it must land on the cycle the next frame pops
    spi_stall = 1'b0;
    bus.I_cmd_valid = 1'b1;
    bus.I_cmd_ch = 5'd16;
    bus.I_cmd_pos = 12'hFED;
    acc6 = 1'b0;
    for (int i = 0; i < 400 && !acc6; i++) begin
      @(negedge clk);
      if (bus.O_cmd_ready) begin
        acc6 = 1'b1;
        chk("t4_push_on_pop_txen", bus.O_tx_en, 0);
      end
    end
    @(negedge clk);
    bus.I_cmd_valid = 1'b0;
    chk("t4_push_on_pop", acc6, 1);
    wait_frames("t4_frames", f0 + 6, 800);
    check_bytes("t4_byte", exp4, 30);

    // reset during byte 2 aborts the frame and drops the queue
    rx_q.delete();
    send_cmd(5'd7, 12'h3C4);
    wait_tx_en("t5_send", 20);
    send_cmd(5'd4, 12'h444);
    for (int i = 0; i < 200 && bif < 2; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    chk("t5_byte2", bus.O_data_out, 8'h03);
    f0 = frames;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_en", bus.O_tx_en, 0);
    chk("t5_rst_data", bus.O_data_out, 8'h00);
    repeat (2) @(negedge clk);
    chk("t5_rst_busy", bus.O_busy, 0);
    chk("t5_rst_ready", bus.O_cmd_ready, 1);
    rst_n = 1'b1;
    rx_q.delete();
    repeat (150) @(negedge clk);
    chk("t5_no_frame_done", frames, f0);
    chk("t5_queue_lost", rx_q.size(), 0);
    send_cmd(5'd3, 12'h5A7);
    wait_frames("t5_frames", f0 + 1, 300);
    check_bytes("t5_byte", exp1, 5);

    repeat (5) @(negedge clk);
    chk("err_pulses", err_cnt, 1);
    chk("tx_en_gaps", gap_errs, 0);
    chk("data_stable", stab_errs, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/servo_frame_tx.md
SERVO_FRAME_TX -- requirements
Module: servo_frame_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter HEADER, default 8'hAA, first byte of every frame.
REQ-003 Parameter MAX_CH, default 17, highest legal servo channel.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 I_cmd_valid  input  1  command offered this cycle.
REQ-007 I_cmd_ch  input  5  servo channel number.
REQ-008 I_cmd_pos  input  12  servo pulse/position value.
REQ-009 O_cmd_ready  output  1  FIFO can accept a command (not full).
REQ-010 O_tx_en  output  1  byte request to the downstream SPI master.
REQ-011 O_data_out  output  8  byte presented to the SPI master.
REQ-012 I_tx_done  input  1  one-cycle pulse from SPI master: current byte shifted out.
REQ-013 O_busy  output  1  frame in progress or FIFO non-empty.
REQ-014 O_frame_done  output  1  one-cycle pulse after the last byte of a frame completes.
REQ-015 O_cmd_err  output  1  one-cycle pulse when an accepted command has channel > MAX_CH.

Function
REQ-016 Command is accepted on a cycle with I_cmd_valid=1 and O_cmd_ready=1; otherwise ignored, no error.
REQ-017 Accepted command with I_cmd_ch > MAX_CH is discarded (not written to FIFO) and O_cmd_err pulses the following cycle.
REQ-018 Frame = 5 bytes in order: HEADER, {3'b0,ch}, {4'b0,pos[11:8]}, pos[7:0], CHK, where CHK = XOR of bytes 1..3.
REQ-019 FSM states: IDLE, LOAD, SEND, LAST; IDLE->LOAD when FIFO non-empty; LOAD pops one entry, builds frame, ->SEND next cycle.
REQ-020 In SEND, O_tx_en=1 and O_data_out=byte[idx]; O_data_out is held stable until I_tx_done is sampled high.
REQ-021 On I_tx_done with idx<4: idx increments, O_data_out shows next byte the following cycle, O_tx_en remains 1 (no gap between bytes of a frame).
REQ-022 On I_tx_done with idx=4: ->LAST; O_tx_en=0 and O_frame_done=1 the following cycle; then ->IDLE (or LOAD if FIFO non-empty) next cycle.
REQ-023 Minimum O_tx_en low time between frames: 2 cycles (LAST + LOAD).
REQ-024 I_tx_done while not in SEND is ignored.
REQ-025 Simultaneous push and pop on the same cycle are both performed; occupancy unchanged.
REQ-026 FIFO full: O_cmd_ready=0; offered commands are not stored and not flagged as errors.
REQ-027 FIFO read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-028 O_busy = (state != IDLE) or FIFO non-empty, registered.

Reset
REQ-029 While rst_n=0: state=IDLE, idx=0, FIFO empty, O_tx_en=0, O_data_out=8'h00, O_frame_done=0, O_cmd_err=0, O_busy=0, O_cmd_ready=1 after release.
REQ-030 Reset asserted mid-frame aborts the frame immediately; queued commands are lost; no O_frame_done is issued.

Structure
REQ-031 Shared package holds FSM state encoding, frame length constant (5), byte index constants, default HEADER value.
REQ-032 One sub-module: servo_cmd_fifo (synchronous, FIFO_DEPTH x 17 bits, full/empty flags, same clk/rst_n).
REQ-033 Frame build and checksum are combinational from the popped entry, registered into a 5-byte frame register in LOAD.

Verification
REQ-034 Single command ch=3, pos=12'h5A7, SPI model pulses I_tx_done 16 cycles after each byte -> bytes AA,03,05,A7,A1 in order, O_tx_en continuous across 5 bytes, one O_frame_done.
REQ-035 Five back-to-back commands with SPI stalled -> first four accepted, O_cmd_ready=0 on fifth, after drain exactly 4 frames sent in order.
REQ-036 Command ch=18, pos=12'h100 -> O_cmd_err pulses once, no O_tx_en, O_busy stays 0.
REQ-037 Push on same cycle as LOAD pop with FIFO full -> push accepted, no entry lost or duplicated.
REQ-038 rst_n low during byte 2 of a frame -> O_tx_en=0 immediately, FIFO empty, no O_frame_done; new command afterward sends full frame starting with AA.
REQ-039 Spurious I_tx_done pulse while IDLE -> no output change.
